// File: rtl/coe_sram_server_pkg.sv
// Shared types and constants for the coefficient-SRAM server and its CRC helper.
package coe_sram_server_pkg;

  localparam int unsigned CoeAddrW = 18;
  localparam int unsigned CoeDataW = 16;

  localparam logic [15:0] CrcPoly = 16'h1021;
  localparam logic [15:0] CrcInit = 16'hFFFF;

  localparam int unsigned WrCycMin = 1;
  localparam int unsigned WrCycMax = 3;

  typedef enum logic [2:0] {
    StRead,
    StLoadIdle,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StWrAck
  } coe_state_e;

  // Phase length clamped to the supported range, expressed as the 2-bit counter reload value.
  function automatic logic [1:0] wr_cyc_load(int unsigned cyc);
    int unsigned c;
    c = (cyc < WrCycMin) ? WrCycMin : ((cyc > WrCycMax) ? WrCycMax : cyc);
    return 2'(c - 1);
  endfunction

endpackage

// File: rtl/coe_crc16_step.sv
// Combinational CRC-16/CCITT update over one data word, MSB first.
module coe_crc16_step
  import coe_sram_server_pkg::*;
#(
  parameter int unsigned DATA_W = CoeDataW
) (
  input  logic [15:0]       crc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [15:0]       crc_o
);

  logic [15:0] crc_acc;

  always_comb begin
    crc_acc = crc_i;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (crc_acc[15] ^ data_i[i]) begin
        crc_acc = {crc_acc[14:0], 1'b0} ^ CrcPoly;
      end else begin
        crc_acc = {crc_acc[14:0], 1'b0};
      end
    end
    crc_o = crc_acc;
  end

endmodule

// File: rtl/coe_sram_server.sv
// Coefficient-SRAM responder: pipelined reads for the calculation path, timed loader writes.
// Optional load-data CRC output enabled by defining COE_SRAM_CRC_EN.
module coe_sram_server
  import coe_sram_server_pkg::*;
#(
  parameter int unsigned ADDR_W       = CoeAddrW,
  parameter int unsigned DATA_W       = CoeDataW,
  parameter int unsigned WR_SETUP_CYC = 1,
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter int unsigned WR_HOLD_CYC  = 1
) (
  input  logic              i_clk_50m,
  input  logic              i_rst,
  input  logic              i_load_mode,
  input  logic [ADDR_W-1:0] i_coe_sram_addr,
  output logic [DATA_W-1:0] o_coe_sram_data,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_wr_count,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n
`ifdef COE_SRAM_CRC_EN
  ,
  output logic [15:0]       o_load_crc
`endif
);

  localparam logic [1:0] SetupLoad = wr_cyc_load(WR_SETUP_CYC);
  localparam logic [1:0] PulseLoad = wr_cyc_load(WR_PULSE_CYC);
  localparam logic [1:0] HoldLoad  = wr_cyc_load(WR_HOLD_CYC);

  coe_state_e        state_q;
  logic [1:0]        cnt_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [DATA_W-1:0] sram_wdata_q;
  logic [DATA_W-1:0] coe_data_q;
  logic [ADDR_W-1:0] wr_count_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic              wr_ack_q;
  logic              busy_q;

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      state_q      <= StRead;
      cnt_q        <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      coe_data_q   <= '0;
      wr_count_q   <= '0;
      oe_n_q       <= 1'b0;
      we_n_q       <= 1'b1;
      wr_ack_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_ack_q <= 1'b0;
      unique case (state_q)
        StRead: begin
          // Two-stage read pipe: address pins this cycle, pad data on the next.
          sram_addr_q <= i_coe_sram_addr;
          coe_data_q  <= i_sram_rdata;
          if (i_load_mode) begin
            state_q    <= StLoadIdle;
            oe_n_q     <= 1'b1;
            busy_q     <= 1'b1;
            coe_data_q <= '0;
            wr_count_q <= '0;
          end
        end
        StLoadIdle: begin
          // A pending request wins over a mode drop; the mode is re-checked after the ack.
          if (i_wr_req) begin
            state_q      <= StWrSetup;
            sram_addr_q  <= i_wr_addr;
            sram_wdata_q <= i_wr_data;
            cnt_q        <= SetupLoad;
          end else if (!i_load_mode) begin
            state_q <= StRead;
            oe_n_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        StWrSetup: begin
          if (cnt_q == 2'd0) begin
            state_q <= StWrPulse;
            we_n_q  <= 1'b0;
            cnt_q   <= PulseLoad;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StWrPulse: begin
          if (cnt_q == 2'd0) begin
            state_q <= StWrHold;
            we_n_q  <= 1'b1;
            cnt_q   <= HoldLoad;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StWrHold: begin
          // Count is updated together with the ack so both are visible in the same cycle.
          if (cnt_q == 2'd0) begin
            state_q    <= StWrAck;
            wr_ack_q   <= 1'b1;
            wr_count_q <= wr_count_q + ADDR_W'(1);
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StWrAck: begin
          if (i_load_mode) begin
            state_q <= StLoadIdle;
          end else begin
            state_q <= StRead;
            oe_n_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StRead;
      endcase
    end
  end

  assign o_coe_sram_data = coe_data_q;
  assign o_wr_ack        = wr_ack_q;
  assign o_busy          = busy_q;
  assign o_wr_count      = wr_count_q;
  assign o_sram_addr     = sram_addr_q;
  assign o_sram_wdata    = sram_wdata_q;
  assign o_sram_ce_n     = 1'b0;
  assign o_sram_oe_n     = oe_n_q;
  assign o_sram_we_n     = we_n_q;

`ifdef COE_SRAM_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_next;

  coe_crc16_step #(
    .DATA_W (DATA_W)
  ) u_crc16_step (
    .crc_i  (crc_q),
    .data_i (sram_wdata_q),
    .crc_o  (crc_next)
  );

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      crc_q <= CrcInit;
    end else if (state_q == StRead && i_load_mode) begin
      crc_q <= CrcInit;
    end else if (state_q == StWrHold && cnt_q == 2'd0) begin
      crc_q <= crc_next;
    end
  end

  assign o_load_crc = crc_q;
`endif

endmodule

// File: tb/tb_coe_sram_server.sv
// Self-checking bench for coe_sram_server: scoreboard of expected outputs per cycle plus literals.
module tb_coe_sram_server;

  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int SETUP = 1;
  localparam int PULSE = 2;
  localparam int HOLD  = 1;
  localparam int WRLEN = SETUP + PULSE + HOLD + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_mode = 1'b0;
  logic [AW-1:0] coe_addr = '0;
  logic [DW-1:0] coe_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          busy;
  logic [AW-1:0] wr_count;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          ce_n;
  logic          oe_n;
  logic          we_n;
`ifdef COE_SRAM_CRC_EN
  logic [15:0]   load_crc;
`endif

  always #10 clk = ~clk;

  coe_sram_server u_dut (
    .i_clk_50m       (clk),
    .i_rst           (rst),
    .i_load_mode     (load_mode),
    .i_coe_sram_addr (coe_addr),
    .o_coe_sram_data (coe_data),
    .i_wr_req        (wr_req),
    .i_wr_addr       (wr_addr),
    .i_wr_data       (wr_data),
    .o_wr_ack        (wr_ack),
    .o_busy          (busy),
    .o_wr_count      (wr_count),
    .o_sram_addr     (sram_addr),
    .o_sram_wdata    (sram_wdata),
    .i_sram_rdata    (sram_rdata),
    .o_sram_ce_n     (ce_n),
    .o_sram_oe_n     (oe_n),
    .o_sram_we_n     (we_n)
`ifdef COE_SRAM_CRC_EN
    ,
    .o_load_crc      (load_crc)
`endif
  );

  // Asynchronous SRAM device: unwritten cells return addr+0x100, writes land on WE_n rising.
  logic [DW-1:0] sram_mem [int];
  int            sram_wr_ev = 0;

  function automatic logic [DW-1:0] sram_read(logic [AW-1:0] a);
    if (sram_mem.exists(int'(a))) return sram_mem[int'(a)];
    return DW'(a + 18'h100);
  endfunction

  always @(sram_addr or sram_wr_ev) sram_rdata = sram_read(sram_addr);

  always @(posedge we_n) begin
    if (!rst && ce_n == 1'b0) begin
      sram_mem[int'(sram_addr)] = sram_wdata;
      sram_wr_ev++;
    end
  end

  // Behavioural model state
  logic [DW-1:0] model_mem [int];
  int            model_count = 0;
  logic [15:0]   model_crc = 16'hFFFF;

  typedef struct packed {
    logic          we_n;
    logic          oe_n;
    logic          busy;
    logic          ack;
    logic [AW-1:0] count;
  } ctl_t;

  logic [DW-1:0] rd_exp   [int];
  logic [AW-1:0] addr_exp [int];
  logic [DW-1:0] wd_exp   [int];
  ctl_t          ctl_exp  [int];

  logic [DW-1:0] obs_data  [int];
  logic          obs_ack   [int];
  logic          obs_we    [int];
  logic [AW-1:0] obs_count [int];

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] model_rd(logic [AW-1:0] a);
    if (model_mem.exists(int'(a))) return model_mem[int'(a)];
    return DW'(a + 18'h100);
  endfunction

  function automatic logic [15:0] crc_byte(logic [15:0] c_in, logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // Compare process: every cycle with a scheduled expectation is checked here.
  always @(negedge clk) begin
    obs_data[cyc]  = coe_data;
    obs_ack[cyc]   = wr_ack;
    obs_we[cyc]    = we_n;
    obs_count[cyc] = wr_count;
    if (rd_exp.exists(cyc)) begin
      chk("rd_data", 32'(coe_data), 32'(rd_exp[cyc]));
      rd_exp.delete(cyc);
    end
    if (addr_exp.exists(cyc)) begin
      chk("sram_addr", 32'(sram_addr), 32'(addr_exp[cyc]));
      addr_exp.delete(cyc);
    end
    if (wd_exp.exists(cyc)) begin
      chk("sram_wdata", 32'(sram_wdata), 32'(wd_exp[cyc]));
      wd_exp.delete(cyc);
    end
    if (ctl_exp.exists(cyc)) begin
      chk("we_n", 32'(we_n), 32'(ctl_exp[cyc].we_n));
      chk("oe_n", 32'(oe_n), 32'(ctl_exp[cyc].oe_n));
      chk("busy", 32'(busy), 32'(ctl_exp[cyc].busy));
      chk("wr_ack", 32'(wr_ack), 32'(ctl_exp[cyc].ack));
      chk("wr_count", 32'(wr_count), 32'(ctl_exp[cyc].count));
      chk("ce_n", 32'(ce_n), 32'd0);
      ctl_exp.delete(cyc);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ctl(int c, logic w, logic o, logic b, logic a, int cnt);
    ctl_exp[c] = '{we_n: w, oe_n: o, busy: b, ack: a, count: AW'(cnt)};
  endtask

  // Present one read address; DUT must be in READ this cycle.
  task automatic do_read(logic [AW-1:0] a);
    coe_addr = a;
    rd_exp[cyc + 2]   = model_rd(a);
    addr_exp[cyc + 1] = a;
    push_ctl(cyc, 1'b1, 1'b0, 1'b0, 1'b0, model_count);
    cycle();
  endtask

  // Called in a READ cycle; returns in the first LOAD_IDLE cycle.
  task automatic enter_load();
    load_mode = 1'b1;
    push_ctl(cyc, 1'b1, 1'b0, 1'b0, 1'b0, model_count);
    cycle();
    model_count = 0;
    model_crc   = 16'hFFFF;
    push_ctl(cyc, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    rd_exp[cyc] = '0;
  endtask

  // Called in a LOAD_IDLE cycle (accept); returns in the cycle after the ack.
  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d, bit hold_req, bit drop_in_pulse);
    int t;
    int cnt0;
    t    = cyc + 1;
    cnt0 = model_count;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    model_mem[int'(a)] = d;
    for (int k = 1; k <= WRLEN; k++) begin
      addr_exp[cyc + k] = a;
      wd_exp[cyc + k]   = d;
    end
    for (int k = 0; k < SETUP; k++) push_ctl(t++, 1'b1, 1'b1, 1'b1, 1'b0, cnt0);
    for (int k = 0; k < PULSE; k++) push_ctl(t++, 1'b0, 1'b1, 1'b1, 1'b0, cnt0);
    for (int k = 0; k < HOLD; k++) push_ctl(t++, 1'b1, 1'b1, 1'b1, 1'b0, cnt0);
    push_ctl(t, 1'b1, 1'b1, 1'b1, 1'b1, cnt0 + 1);
    model_count = cnt0 + 1;
    model_crc   = crc_byte(crc_byte(model_crc, d[15:8]), d[7:0]);
    for (int k = 1; k <= WRLEN; k++) begin
      cycle();
      if (drop_in_pulse && k == SETUP + 1) load_mode = 1'b0;
    end
    if (!hold_req) wr_req = 1'b0;
    cycle();
    push_ctl(cyc, 1'b1, load_mode, load_mode, 1'b0, model_count);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int r0;
    int a0;
    int b0;
    int r1;
    int d0;

    repeat (3) cycle();
    @(negedge clk);
    chk("reset_sram_addr", 32'(sram_addr), 32'd0);
    chk("reset_sram_wdata", 32'(sram_wdata), 32'd0);
    chk("reset_ce_n", 32'(ce_n), 32'd0);
    chk("reset_oe_n", 32'(oe_n), 32'd0);
    chk("reset_we_n", 32'(we_n), 32'd1);
    chk("reset_coe_data", 32'(coe_data), 32'd0);
    chk("reset_wr_ack", 32'(wr_ack), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);
    cycle();
    rst = 1'b0;

    // Pipelined reads; a write request in READ must be ignored.
    wr_req  = 1'b1;
    wr_addr = 18'h00055;
    wr_data = 16'hDEAD;
    r0 = cyc;
    do_read(18'h00010);
    do_read(18'h00011);
    do_read(18'h00012);
    wr_req = 1'b0;
    repeat (2) cycle();
    chk("lit_read0", 32'(obs_data[r0 + 2]), 32'h0110);
    chk("lit_read1", 32'(obs_data[r0 + 3]), 32'h0111);
    chk("lit_read2", 32'(obs_data[r0 + 4]), 32'h0112);

    // Single write at the top address
    enter_load();
    a0 = cyc;
    do_write(18'h3FFFF, 16'h1A2B, 1'b0, 1'b0);
    chk("lit_we_setup", 32'(obs_we[a0 + 1]), 32'd1);
    chk("lit_we_pulse0", 32'(obs_we[a0 + 2]), 32'd0);
    chk("lit_we_pulse1", 32'(obs_we[a0 + 3]), 32'd0);
    chk("lit_we_hold", 32'(obs_we[a0 + 4]), 32'd1);
    chk("lit_ack_early", 32'(obs_ack[a0 + 4]), 32'd0);
    chk("lit_ack", 32'(obs_ack[a0 + 5]), 32'd1);
    chk("lit_count1", 32'(obs_count[a0 + 5]), 32'd1);

    // Back-to-back writes with request held
    b0 = cyc;
    for (int i = 0; i < 4; i++) begin
      do_write(18'h00100 + 18'(i), 16'hA000 + 16'(i * 16'h111), i < 3, 1'b0);
    end
    chk("lit_b2b_ack0", 32'(obs_ack[b0 + 5]), 32'd1);
    chk("lit_b2b_gap", 32'(obs_ack[b0 + 6]), 32'd0);
    chk("lit_b2b_ack1", 32'(obs_ack[b0 + 11]), 32'd1);
    chk("lit_b2b_ack3", 32'(obs_ack[b0 + 23]), 32'd1);
    chk("lit_count5", 32'(obs_count[b0 + 23]), 32'd5);
    load_mode = 1'b0;
    cycle();
    do_read(18'h3FFFF);
    do_read(18'h00100);
    r1 = cyc;
    do_read(18'h00101);
    do_read(18'h00102);
    do_read(18'h00103);
    repeat (2) cycle();
    chk("lit_readback", 32'(obs_data[r1 + 2]), 32'hA111);

    // Mode dropped during the write pulse
    enter_load();
    d0 = cyc;
    do_write(18'h02345, 16'h5A5A, 1'b0, 1'b1);
    do_read(18'h02345);
    do_read(18'h00010);
    repeat (2) cycle();
    chk("lit_drop_we", 32'(obs_we[d0 + 3]), 32'd0);
    chk("lit_drop_ack", 32'(obs_ack[d0 + 5]), 32'd1);
    chk("lit_drop_read", 32'(obs_data[d0 + 8]), 32'h5A5A);

    // Reset in the middle of the write pulse
    enter_load();
    wr_req  = 1'b1;
    wr_addr = 18'h00555;
    wr_data = 16'h1234;
    repeat (2) cycle();
    @(negedge clk);
    chk("rst_pre_we", 32'(we_n), 32'd0);
    rst       = 1'b1;
    wr_req    = 1'b0;
    load_mode = 1'b0;
    cycle();
    @(negedge clk);
    chk("rst_we_n", 32'(we_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_coe_data", 32'(coe_data), 32'd0);
    chk("rst_oe_n", 32'(oe_n), 32'd0);
    cycle();
    rst = 1'b0;
    model_count = 0;
    do_read(18'h00020);
    repeat (2) cycle();

`ifdef COE_SRAM_CRC_EN
    enter_load();
    @(negedge clk);
    chk("crc_init", 32'(load_crc), 32'hFFFF);
    do_write(18'h00000, 16'h3132, 1'b1, 1'b0);
    do_write(18'h00001, 16'h3334, 1'b0, 1'b0);
    @(negedge clk);
    chk("crc_model", 32'(load_crc), 32'(model_crc));
    chk("crc_lit_1234", 32'(load_crc), 32'h5349);
    load_mode = 1'b0;
    cycle();
    do_read(18'h00001);
    repeat (2) cycle();
`endif

    repeat (3) cycle();
    chk("pending_expectations",
        32'(rd_exp.num() + addr_exp.num() + wd_exp.num() + ctl_exp.num()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coe_sram_server.md
Name: coe_sram_server

Overview:
- Responder side of the coefficient-SRAM read interface used by the distance/RSSI calculation path.
- Serves 18-bit coefficient addresses from the distance and RSSI stages with fixed-latency 16-bit data.
- Drives the external asynchronous SRAM pins.
- In load mode, accepts coefficient writes from the flash/host loader with timed SRAM write strobes.
- Sits between the distance-calculation top and the SRAM pads.

Parameters:
- ADDR_W, 18, coefficient address width.
- DATA_W, 16, coefficient data width.
- WR_SETUP_CYC, 1, cycles address/data are stable before WE_n falls (1..3).
- WR_PULSE_CYC, 2, cycles WE_n is held low (1..3).
- WR_HOLD_CYC, 1, cycles address/data are held after WE_n rises (1..3).

Ports:
- i_clk_50m  in  1  system clock, 50 MHz.
- i_rst  in  1  reset; synchronous, active-high.
- i_load_mode  in  1  1 = loader owns SRAM, 0 = calculation path owns SRAM.
- i_coe_sram_addr  in  ADDR_W  read address from calculation path; sampled every cycle.
- o_coe_sram_data  out  DATA_W  read data.
- i_wr_req  in  1  loader write request; level, held until ack.
- i_wr_addr  in  ADDR_W  write address.
- i_wr_data  in  DATA_W  write data.
- o_wr_ack  out  1  one-cycle pulse; write completed.
- o_busy  out  1  high whenever in a LOAD-side state.
- o_wr_count  out  ADDR_W  writes completed since last entry to load mode.
- o_sram_addr  out  ADDR_W  SRAM address pins.
- o_sram_wdata  out  DATA_W  SRAM write data; the pad enable is o_sram_oe_n.
- i_sram_rdata  in  DATA_W  SRAM read data pins.
- o_sram_ce_n  out  1  chip enable, active low.
- o_sram_oe_n  out  1  output enable, active low.
- o_sram_we_n  out  1  write enable, active low.

Behaviour:
- Reset values:
  - FSM = READ.
  - All SRAM pin outputs = 0, except ce_n=0, oe_n=0, we_n=1.
  - o_coe_sram_data=0, o_wr_ack=0, o_busy=0, o_wr_count=0.
- FSM states: READ, LOAD_IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WR_ACK.
- READ:
  - Cycle N: i_coe_sram_addr registered to o_sram_addr.
  - Cycle N+1: i_sram_rdata registered to o_coe_sram_data.
  - Read latency is exactly 2 cycles; a new address is accepted every cycle.
  - oe_n=0, we_n=1, i_wr_req ignored (no ack).
  - i_load_mode=1 → LOAD_IDLE; o_wr_count cleared on this transition.
- LOAD_IDLE:
  - oe_n=1, o_busy=1, o_coe_sram_data driven 0.
  - i_wr_req=1 → latch addr/data into o_sram_addr/o_sram_wdata, go to WR_SETUP.
  - If i_load_mode=0 and no request → READ.
  - Request and mode-drop in the same cycle: the write is taken; mode is re-checked after WR_ACK.
- WR_SETUP: we_n=1 for WR_SETUP_CYC cycles, then → WR_PULSE.
- WR_PULSE: we_n=0 for WR_PULSE_CYC cycles, then → WR_HOLD.
- WR_HOLD: we_n=1, addr/data held for WR_HOLD_CYC cycles, then → WR_ACK.
- WR_ACK:
  - o_wr_ack=1 for one cycle; o_wr_count increments and wraps at 2^ADDR_W.
  - Next state is LOAD_IDLE if i_load_mode=1, else READ.
- One shared cycle counter, 2 bits, reloaded on each write-phase entry.
- Mode drop mid-write: the write always completes; the loader never sees a truncated strobe.
- First valid read data appears 2 cycles after READ is re-entered.
- i_wr_req must stay high until ack. A request still high in the cycle after ack starts a new write; the loader deasserts it in the ack cycle.
- Reset mid-write: we_n=1 on the next edge; the interrupted write is undefined and the loader restarts.
- Default write cycle time = 1+2+1+1 = 5 cycles from LOAD_IDLE accept to ack; next accept possible 1 cycle later.

Optional Feature:
- COE_SRAM_CRC_EN defined:
  - Adds output o_load_crc [15:0]: CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB first) over i_wr_data of each acked write.
  - Reset to 0xFFFF on load-mode entry; updated in the WR_ACK cycle.
- Undefined: port and logic absent, all other behaviour identical.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - ADDR_W/DATA_W defaults.
  - CRC polynomial/init constants.
  - Write-timing limits.
- One natural sub-module: coe_crc16_step, a combinational single-word CRC update. It is instantiated only under COE_SRAM_CRC_EN.

Test Plan:
- Reset released, i_load_mode=0, addresses 0x00010, 0x00011, 0x00012 on consecutive cycles with SRAM model returning addr+0x100 → o_coe_sram_data = 0x0110, 0x0111, 0x0112 exactly 2 cycles after each address.
- i_load_mode=1, write 0x1A2B to 0x3FFFF → we_n low exactly 2 cycles, addr/data stable 1 cycle before and after, o_wr_ack 5 cycles after accept, o_wr_count=1.
- 4 back-to-back writes with req held continuously → 4 acks spaced 6 cycles apart; readback in READ mode returns the written data.
- i_load_mode dropped in WR_PULSE → pulse completes full width, ack issued, FSM returns to READ, valid read data 2 cycles later.
- i_rst asserted during WR_PULSE → we_n=1 next edge; o_busy=0, o_wr_count=0, o_coe_sram_data=0.
- COE_SRAM_CRC_EN: writes of 0x3132, 0x3334 → o_load_crc matches the reference CRC-16/CCITT of bytes "1234" (0x5349).
